fifo_sel_arb: RTL

//  Parametrised successor to the fixed 6-port FIFO selector. It arbitrates PORT_NUM

---
 rtl/fifo_sel_arb.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fifo_sel_arb.sv
// fifo_sel_arb: registered grant arbiter for PORT_NUM FIFO request flags.
// Fixed-priority or round-robin selection. The grant is held until the consumer
// releases it or the granted request drops.
// Optional build macro FIFO_SEL_TIMEOUT_EN adds a hold counter that forces a
// release after MAX_HOLD grant cycles and pulses sel_timeout.
module fifo_sel_arb #(
   parameter int unsigned PORT_NUM = 6,
   parameter int unsigned IDX_W    = 3,
   parameter int unsigned MAX_HOLD = 255
) (
   input  logic                glb_clk,
   input  logic                glb_rst,
   input  logic [PORT_NUM-1:0] fifo_sel_bits,
   input  logic                rr_mode,
   input  logic                pkt_done,
   output logic                sel_valid,
   output logic [IDX_W-1:0]    sel_idx,
   output logic [PORT_NUM-1:0] sel_onehot,
   output logic [7:0]          sel_code,
   output logic                sel_timeout
);

   // Elaboration-time parameter sanity checks
   if (PORT_NUM < 2 || PORT_NUM > 128) begin : g_bad_port_num
      $error("fifo_sel_arb: PORT_NUM out of range");
   end
   if (IDX_W < $clog2(PORT_NUM)) begin : g_bad_idx_w
      $error("fifo_sel_arb: IDX_W too narrow for PORT_NUM");
   end
   if (MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_max_hold
      $error("fifo_sel_arb: MAX_HOLD out of range");
   end

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [PORT_NUM-1:0] onehot_q, onehot_d;
   logic [7:0]          code_q, code_d;

   logic [IDX_W-1:0]    win_idx;
   logic [PORT_NUM-1:0] cand;
   logic [PORT_NUM-1:0] cand_hi;
   logic [PORT_NUM-1:0] above_ptr;
   logic                held_req;
   logic                release_grant;
   logic                do_arb;
   logic                hold_expired;

`ifdef FIFO_SEL_TIMEOUT_EN
   logic [15:0] hold_q, hold_d;
   logic        timeout_q, timeout_d;

   // Last allowed grant cycle: the count starts at 0 on the first grant cycle
   assign hold_expired = (state_q == StGrant) && (hold_q == 16'(MAX_HOLD - 1));
`else
   assign hold_expired = 1'b0;
`endif

   // Index of the lowest set bit; 0 for an empty vector
   function automatic logic [IDX_W-1:0] lowest_set(input logic [PORT_NUM-1:0] vec);
      logic [IDX_W-1:0] res;
      logic             found;
      res   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < PORT_NUM; i++) begin
         if (vec[i] && !found) begin
            res   = IDX_W'(i);
            found = 1'b1;
         end
      end
      return res;
   endfunction

   // Release detection and winner selection
   always_comb begin
      held_req      = |(fifo_sel_bits & onehot_q);
      release_grant = (state_q == StGrant) && (pkt_done || !held_req || hold_expired);

      // Released port steps aside unless it is the only requester left
      cand = fifo_sel_bits;
      if (release_grant && (|(fifo_sel_bits & ~onehot_q))) begin
         cand = fifo_sel_bits & ~onehot_q;
      end

      // Round-robin: ports above the pointer first, then wrap to the bottom
      for (int unsigned i = 0; i < PORT_NUM; i++) begin
         above_ptr[i] = (i > 32'(ptr_q));
      end
      cand_hi = cand & above_ptr;

      if (rr_mode && (|cand_hi)) begin
         win_idx = lowest_set(cand_hi);
      end else begin
         win_idx = lowest_set(cand);
      end

      do_arb = (|cand) && ((state_q == StIdle) || release_grant);
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      ptr_d    = ptr_q;
      onehot_d = onehot_q;
      code_d   = code_q;

      unique case (state_q)
         StIdle: begin
            // pkt_done is ignored here; only requests matter
         end
         StGrant: begin
            if (release_grant && !do_arb) begin
               state_d  = StIdle;
               idx_d    = '0;
               onehot_d = '0;
               code_d   = '0;
            end
         end
         default: begin
            state_d  = StIdle;
            idx_d    = '0;
            onehot_d = '0;
            code_d   = '0;
         end
      endcase

      if (do_arb) begin
         state_d  = StGrant;
         idx_d    = win_idx;
         ptr_d    = win_idx;
         onehot_d = PORT_NUM'(1) << win_idx;
         code_d   = 8'(32'd128 + 32'(win_idx));
      end
   end

`ifdef FIFO_SEL_TIMEOUT_EN
   // Hold counter and forced-release pulse
   always_comb begin
      hold_d    = hold_q;
      timeout_d = 1'b0;
      if (state_q == StGrant) begin
         hold_d = hold_q + 16'd1;
      end
      if (do_arb) begin
         hold_d = '0;
      end
      // Only a pure timeout counts as forced; a coincident normal release wins
      timeout_d = hold_expired && !pkt_done && held_req;
   end

   // Hold counter registers
   always_ff @(posedge glb_clk) begin
      if (glb_rst) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign sel_timeout = timeout_q;
`else
   assign sel_timeout = 1'b0;
`endif

   // Grant state registers
   always_ff @(posedge glb_clk) begin
      if (glb_rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         ptr_q    <= IDX_W'(PORT_NUM - 1);
         onehot_q <= '0;
         code_q   <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         ptr_q    <= ptr_d;
         onehot_q <= onehot_d;
         code_q   <= code_d;
      end
   end

   assign sel_valid  = (state_q == StGrant);
   assign sel_idx    = idx_q;
   assign sel_onehot = onehot_q;
   assign sel_code   = code_q;

endmodule
